// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: registered N-way arbiter with a valid/ready grant handshake.
// Selects either fixed priority (highest index wins) or round-robin at each
// arbitration decision. The grant index and one-hot are held until accepted.
module prio_rr_arbiter #(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rr_mode,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot
);

    localparam int unsigned NU = N;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] scan_ptr;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_onehot;
    logic            handshake;
    logic            found;
    int unsigned     cand;

    // On a handshake the just-served index becomes the round-robin pointer
    // for the decision made in that same cycle.
    assign handshake = (state == GRANT) && gnt_ready;
    assign scan_ptr  = handshake ? gnt_idx : ptr;

    // Winner selection: highest set bit, or first set bit scanning down from
    // scan_ptr-1 with wrap, scan_ptr itself checked last.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        found      = 1'b0;
        cand       = 0;
        if (!rr_mode) begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (req[IDXW'(i)]) begin
                    win_idx = IDXW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NU; k++) begin
                cand = (32'(scan_ptr) + NU - k) % NU;
                if (!found && req[IDXW'(cand)]) begin
                    win_idx = IDXW'(cand);
                    found   = 1'b1;
                end
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    // Grant FSM with registered outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= win_onehot;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        ptr <= gnt_idx;
                        if (|req) begin
                            gnt_idx    <= win_idx;
                            gnt_onehot <= win_onehot;
                        end else begin
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_idx    <= '0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_idx    <= '0;
                    gnt_onehot <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Testbench for prio_rr_arbiter: an N=4 and an N=5 instance driven in
// parallel, checked against a behavioural model after every clock edge.
module tb_prio_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req4 = '0;
    logic [4:0] req5 = '0;
    logic       rr_mode = 1'b0;
    logic       gnt_ready = 1'b0;

    logic       v4;
    logic [1:0] i4;
    logic [3:0] o4;
    logic       v5;
    logic [2:0] i5;
    logic [4:0] o5;

    int compared = 0;
    int mismatched = 0;

    // Model state per instance: [0] is N=4, [1] is N=5
    int nn[2] = '{4, 5};
    int mv[2];
    int mi[2];
    int mp[2];

    prio_rr_arbiter #(.N(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req4),
        .rr_mode    (rr_mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (v4),
        .gnt_idx    (i4),
        .gnt_onehot (o4)
    );

    prio_rr_arbiter #(.N(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req5),
        .rr_mode    (rr_mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (v5),
        .gnt_idx    (i5),
        .gnt_onehot (o5)
    );

    initial forever #5 clk = ~clk;

    // Winner by rule: fixed = largest requesting index; round-robin = the
    // requester with the smallest downward distance from p-1 (p itself last).
    function automatic int win(input int n, input int r, input int p, input bit md);
        int best = 0;
        int bestd = n;
        int d;
        for (int i = 0; i < n; i++) begin
            if (((r >> i) & 1) == 1) begin
                if (!md) begin
                    best = i;
                end else begin
                    d = (p - 1 - i + 2 * n) % n;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0;
            mi[k] = 0;
            mp[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input int r, input bit rdy, input bit md);
        if (mv[k] == 0) begin
            if (r != 0) begin
                mv[k] = 1;
                mi[k] = win(nn[k], r, mp[k], md);
            end
        end else if (rdy) begin
            mp[k] = mi[k];
            if (r != 0) begin
                mi[k] = win(nn[k], r, mp[k], md);
            end else begin
                mv[k] = 0;
                mi[k] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid4", 32'(v4), 32'(mv[0]));
        check("idx4", 32'(i4), 32'(mi[0]));
        check("onehot4", 32'(o4), (mv[0] != 0) ? (32'd1 << mi[0]) : 32'd0);
        check("valid5", 32'(v5), 32'(mv[1]));
        check("idx5", 32'(i5), 32'(mi[1]));
        check("onehot5", 32'(o5), (mv[1] != 0) ? (32'd1 << mi[1]) : 32'd0);
        check("idx5_range", 32'(i5 < 3'd5), 32'd1);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases early.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        req4 = '0;
        req5 = '0;
        gnt_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    // Drive inputs, take one edge, update the model, then check #1 later.
    task automatic step(input logic [4:0] r, input logic rdy, input logic md);
        req4 = r[3:0];
        req5 = r;
        gnt_ready = rdy;
        rr_mode = md;
        @(posedge clk);
        model_edge(0, int'(r[3:0]), rdy, md);
        model_edge(1, int'(r), rdy, md);
        #1;
        check_all();
    endtask

    initial begin
        logic [4:0] r;
        logic       rdy;
        logic       md;

        #1;
        apply_reset();

        // Fixed priority, req=0110, ready held: idx 2 every cycle
        step(5'b00110, 1'b1, 1'b0);
        check("t1_idx", 32'(i4), 32'd2);
        check("t1_onehot", 32'(o4), 32'b0100);
        step(5'b00110, 1'b1, 1'b0);
        check("t1_repeat", 32'(i4), 32'd2);

        // Round-robin, all requesting: 3,2,1,0,3,2 with no bubbles
        apply_reset();
        begin
            int seq[6] = '{3, 2, 1, 0, 3, 2};
            for (int s = 0; s < 6; s++) begin
                step(5'b01111, 1'b1, 1'b1);
                check("t2_valid", 32'(v4), 32'd1);
                check("t2_idx", 32'(i4), 32'(seq[s]));
            end
        end

        // Grant held while not ready, dropped after the handshake
        apply_reset();
        step(5'b01000, 1'b0, 1'b0);
        check("t3_idx_a", 32'(i4), 32'd3);
        step(5'b00000, 1'b0, 1'b0);
        check("t3_idx_b", 32'(i4), 32'd3);
        step(5'b00000, 1'b0, 1'b0);
        check("t3_idx_c", 32'(i4), 32'd3);
        step(5'b00000, 1'b1, 1'b0);
        check("t3_after_hs", 32'(v4), 32'd0);

        // Round-robin wrap from ptr=0 after serving idx 0
        apply_reset();
        step(5'b00001, 1'b0, 1'b1);
        check("t4_serve0", 32'(i4), 32'd0);
        step(5'b00011, 1'b1, 1'b1);
        check("t4_wrap", 32'(i4), 32'd1);
        step(5'b00001, 1'b1, 1'b1);
        check("t4_then0", 32'(i4), 32'd0);

        // Reset while a grant is held, then round-robin restarts at N-1
        apply_reset();
        step(5'b00100, 1'b0, 1'b0);
        check("t5_pre", 32'(i4), 32'd2);
        #2;
        apply_reset();
        check("t5_async_valid", 32'(v4), 32'd0);
        check("t5_async_onehot", 32'(o4), 32'd0);
        step(5'b01111, 1'b1, 1'b1);
        check("t5_first", 32'(i4), 32'd3);

        // N=5 round-robin between requesters 4 and 0
        apply_reset();
        begin
            int seq5[4] = '{4, 0, 4, 0};
            for (int s = 0; s < 4; s++) begin
                step(5'b10001, 1'b1, 1'b1);
                check("t6_idx", 32'(i5), 32'(seq5[s]));
            end
        end

        // Randomized traffic with occasional mode flips and resets
        apply_reset();
        md = 1'b0;
        for (int s = 0; s < 400; s++) begin
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) r = r & 5'($urandom_range(0, 31));
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) md = ~md;
            step(r, rdy, md);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                apply_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
